d5m_pattern_gen: RTL and testbench

Synthesizable D5M sensor-side pixel source: drives frame-valid, line-valid and 12-bit Bayer data exactly as the camera header does, so the capture → Bayer-to-RGB → grayscale/edge chain can be exercised without a physical sensor. Sits in front of the capture block, muxed against the GPIO1 camera pins, and is also the stimulus source for camera-path benches. Generates single or continuous frames with programmable geometry and one of four data patterns.

---
 rtl/d5m_pattern_gen.sv | 168 ++++++++++++++++
 tb/tb_d5m_pattern_gen.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/d5m_pattern_gen.sv
// rtl/d5m_pattern_gen.sv - D5M-style FVAL/LVAL/12-bit Bayer pixel source with programmable geometry.
// Optional completed-frame counter: define PATGEN_FRAME_CNT_EN.
module d5m_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 16,
    parameter int FV_LEAD  = 4,
    parameter int FV_TRAIL = 4,
    parameter int V_BLANK  = 32
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic        iCONT,
    input  logic [1:0]  iMODE,
    input  logic [11:0] iCONST,
    output logic [11:0] oD,
    output logic        oFVAL,
    output logic        oLVAL,
    output logic [10:0] oX,
    output logic [10:0] oY,
    output logic        oFRAME_DONE,
    output logic [15:0] oFRAME_CNT
);
    typedef enum logic [2:0] {IDLE, LEAD, ACTIVE, HBLANK, TRAIL, VBLANK} state_t;

    localparam logic [15:0] LEAD_M1  = 16'(FV_LEAD - 1);
    localparam logic [15:0] HB_M1    = 16'(H_BLANK - 1);
    localparam logic [15:0] TRAIL_M1 = 16'(FV_TRAIL - 1);
    localparam logic [15:0] VB_M1    = 16'(V_BLANK - 1);
    localparam logic [10:0] HA_M1    = 11'(H_ACTIVE - 1);
    localparam logic [10:0] VA_M1    = 11'(V_ACTIVE - 1);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [10:0] r_x, w_x_nxt, r_y, w_y_nxt;
    logic        r_pend, w_pend_nxt;
    logic [1:0]  r_mode;
    logic [11:0] r_const, r_lfsr, w_pix;
    logic [11:0] r_d;
    logic        r_fval, r_lval, r_done;
    logic        w_lead_entry, w_lfsr_fb;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        case (r_state)
            IDLE: if (iSTART || iCONT) begin
                w_state_nxt = LEAD;
                w_cnt_nxt   = '0;
                w_x_nxt     = '0;
                w_y_nxt     = '0;
            end
            LEAD: if (r_cnt == LEAD_M1) begin
                w_state_nxt = ACTIVE;
                w_x_nxt     = '0;
                w_y_nxt     = '0;
            end else begin
                w_cnt_nxt = r_cnt + 16'd1;
            end
            ACTIVE: if (r_x == HA_M1) begin
                w_cnt_nxt = '0;
                if (r_y != VA_M1) begin
                    w_state_nxt = HBLANK;
                    w_y_nxt     = r_y + 11'd1;
                end else begin
                    w_state_nxt = TRAIL;
                end
            end else begin
                w_x_nxt = r_x + 11'd1;
            end
            HBLANK: if (r_cnt == HB_M1) begin
                w_state_nxt = ACTIVE;
                w_x_nxt     = '0;
            end else begin
                w_cnt_nxt = r_cnt + 16'd1;
            end
            TRAIL: if (r_cnt == TRAIL_M1) begin
                w_state_nxt = VBLANK;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt = r_cnt + 16'd1;
            end
            VBLANK: if (r_cnt == VB_M1) begin
                w_cnt_nxt = '0;
                w_x_nxt   = '0;
                w_y_nxt   = '0;
                w_state_nxt = (iCONT || r_pend || iSTART) ? LEAD : IDLE;
            end else begin
                w_cnt_nxt = r_cnt + 16'd1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A request arriving while a frame is in flight is remembered once and consumed by the next LEAD entry.
    assign w_lead_entry = (w_state_nxt == LEAD) && (r_state != LEAD);
    assign w_pend_nxt   = w_lead_entry ? 1'b0 :
                          ((iSTART && (r_state != IDLE)) ? 1'b1 : r_pend);
    assign w_lfsr_fb    = r_lfsr[11] ^ r_lfsr[10] ^ r_lfsr[9] ^ r_lfsr[3];

    always_comb begin
        w_pix = '0;
        case (r_mode)
            2'd0: w_pix = r_const;
            2'd1: w_pix = {1'b0, w_x_nxt};
            2'd2: w_pix = (w_x_nxt[0] ^ w_y_nxt[0]) ? 12'hFFF : 12'h000;
            default: w_pix = r_lfsr;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_pend  <= 1'b0;
            r_mode  <= '0;
            r_const <= '0;
            r_lfsr  <= 12'hACE;
            r_d     <= '0;
            r_fval  <= 1'b0;
            r_lval  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_pend  <= w_pend_nxt;
            if (w_lead_entry) begin
                r_mode  <= iMODE;
                r_const <= iCONST;
                r_lfsr  <= 12'hACE;
            end else if (w_state_nxt == ACTIVE) begin
                r_lfsr <= {r_lfsr[10:0], w_lfsr_fb};
            end
            r_d    <= (w_state_nxt == ACTIVE) ? w_pix : 12'h000;
            r_fval <= (w_state_nxt != IDLE) && (w_state_nxt != VBLANK);
            r_lval <= (w_state_nxt == ACTIVE);
            r_done <= (w_state_nxt == TRAIL) && (w_cnt_nxt == TRAIL_M1);
        end
    end

`ifdef PATGEN_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_frame_cnt <= '0;
        end else if (r_done) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end
    assign oFRAME_CNT = r_frame_cnt;
`else
    assign oFRAME_CNT = 16'd0;
`endif

    assign oD          = r_d;
    assign oFVAL       = r_fval;
    assign oLVAL       = r_lval;
    assign oX          = r_x;
    assign oY          = r_y;
    assign oFRAME_DONE = r_done;
endmodule

// File: tb/tb_d5m_pattern_gen.sv
// tb/tb_d5m_pattern_gen.sv - Directed table-driven bench for d5m_pattern_gen on a 4x2 frame.
module tb_d5m_pattern_gen;
    logic        clk = 1'b0;
    logic        rst, start, cont;
    logic [1:0]  mode;
    logic [11:0] cst;
    logic [11:0] d;
    logic        fval, lval, done;
    logic [10:0] x, y;
    logic [15:0] fcnt;

    always #5 clk = ~clk;

    d5m_pattern_gen #(
        .H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(2),
        .FV_LEAD(1), .FV_TRAIL(1), .V_BLANK(3)
    ) dut (
        .iCLK(clk), .iRST(rst), .iSTART(start), .iCONT(cont),
        .iMODE(mode), .iCONST(cst),
        .oD(d), .oFVAL(fval), .oLVAL(lval), .oX(x), .oY(y),
        .oFRAME_DONE(done), .oFRAME_CNT(fcnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Monitor state, written only by the monitor process.
    logic [11:0] d_q[$];
    int          x_q[$], y_q[$], len_q[$], gap_q[$];
    int          done_cnt, rises, lrises, viol, run, low_run;
    logic        have_fall, prev_f, prev_l;
    logic        clr_req = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (clr_req) begin
                d_q.delete(); x_q.delete(); y_q.delete(); len_q.delete(); gap_q.delete();
                done_cnt = 0; rises = 0; lrises = 0; viol = 0; run = 0; low_run = 0;
                have_fall = 1'b0;
            end else begin
                if (fval) begin
                    if (!prev_f) begin
                        rises++;
                        if (have_fall) gap_q.push_back(low_run);
                        run = 0;
                    end
                    run++;
                end else begin
                    if (prev_f) begin
                        len_q.push_back(run);
                        have_fall = 1'b1;
                        low_run = 0;
                    end
                    low_run++;
                end
                if (lval && !prev_l) lrises++;
                if (lval) begin
                    d_q.push_back(d);
                    x_q.push_back(int'(x));
                    y_q.push_back(int'(y));
                end
                if (lval && !fval) viol++;
                if (!lval && d != 12'h000) viol++;
                if (done) done_cnt++;
            end
            prev_f = fval;
            prev_l = lval;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mon_clear();
        clr_req = 1'b1;
        @(negedge clk);
        #1;
        clr_req = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int k;
        k = 0;
        while (len_q.size() < n && k < 200) begin
            step();
            k++;
        end
        if (len_q.size() < n) chk("frame_timeout", len_q.size(), n);
        step(8);
    endtask

    task automatic check_frame(input string tag, input logic [0:7][11:0] exp_d);
        chk({tag, "_nframes"}, len_q.size(), 1);
        if (len_q.size() > 0) chk({tag, "_fval_len"}, len_q[0], 12);
        chk({tag, "_lval_bursts"}, lrises, 2);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_npix"}, d_q.size(), 8);
        for (int i = 0; i < 8 && i < d_q.size(); i++) begin
            chk($sformatf("%s_d%0d", tag, i), int'(d_q[i]), int'(exp_d[i]));
            chk($sformatf("%s_x%0d", tag, i), x_q[i], i % 4);
            chk($sformatf("%s_y%0d", tag, i), y_q[i], i / 4);
        end
        chk({tag, "_viol"}, viol, 0);
    endtask

    typedef struct {
        logic [1:0]           mode;
        logic [11:0]          cst;
        logic [0:7][11:0]     exp_d;
    } vec_t;
    vec_t vecs[4];

    initial begin
        int k;
        vecs[0] = '{2'd0, 12'h5A5, {12'h5A5, 12'h5A5, 12'h5A5, 12'h5A5,
                                     12'h5A5, 12'h5A5, 12'h5A5, 12'h5A5}};
        vecs[1] = '{2'd1, 12'h000, {12'h000, 12'h001, 12'h002, 12'h003,
                                     12'h000, 12'h001, 12'h002, 12'h003}};
        vecs[2] = '{2'd2, 12'h000, {12'h000, 12'hFFF, 12'h000, 12'hFFF,
                                     12'hFFF, 12'h000, 12'hFFF, 12'h000}};
        vecs[3] = '{2'd3, 12'h000, {12'hACE, 12'h59D, 12'hB3A, 12'h675,
                                     12'hCEA, 12'h9D5, 12'h3AB, 12'h756}};

        rst = 1'b1; start = 1'b0; cont = 1'b0; mode = 2'd0; cst = 12'h000;
        step(3);
        chk("rst_fval", int'(fval), 0);
        chk("rst_lval", int'(lval), 0);
        chk("rst_d", int'(d), 0);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fcnt", int'(fcnt), 0);
        rst = 1'b0;
        step(2);

        for (int v = 0; v < 4; v++) begin
            mode = vecs[v].mode;
            cst  = vecs[v].cst;
            mon_clear();
            pulse_start();
            chk($sformatf("v%0d_fval_latency", v), int'(fval), 1);
            wait_frames(1);
            check_frame($sformatf("v%0d", v), vecs[v].exp_d);
        end

        // Mode change mid-frame must not affect the frame in flight.
        mode = 2'd3;
        mon_clear();
        pulse_start();
        k = 0;
        while (!lval && k < 50) begin step(); k++; end
        chk("midmode_lval_seen", int'(lval), 1);
        mode = 2'd0;
        cst  = 12'h123;
        wait_frames(1);
        check_frame("midmode_lfsr", vecs[3].exp_d);
        mon_clear();
        pulse_start();
        wait_frames(1);
        check_frame("midmode_next", {8{12'h123}});

        // Two extra requests during one frame yield exactly one extra frame.
        mode = 2'd1;
        mon_clear();
        pulse_start();
        step(2);
        pulse_start();
        step(3);
        pulse_start();
        wait_frames(2);
        step(30);
        chk("dbl_nframes", len_q.size(), 2);
        chk("dbl_done_cnt", done_cnt, 2);
        if (gap_q.size() > 0) chk("dbl_gap", gap_q[0], 3);
        else chk("dbl_gap_present", gap_q.size(), 1);
        chk("dbl_idle_fval", int'(fval), 0);

        // Continuous mode for three frames, dropped during the third.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        mon_clear();
        cont = 1'b1;
        k = 0;
        while (rises < 3 && k < 200) begin step(); k++; end
        chk("cont_third_rise", rises, 3);
        cont = 1'b0;
        wait_frames(3);
        step(30);
        chk("cont_nframes", len_q.size(), 3);
        chk("cont_ngaps", gap_q.size(), 2);
        for (int i = 0; i < gap_q.size(); i++)
            chk($sformatf("cont_gap%0d", i), gap_q[i], 3);
        chk("cont_done_cnt", done_cnt, 3);
`ifdef PATGEN_FRAME_CNT_EN
        chk("cont_fcnt", int'(fcnt), 3);
`else
        chk("cont_fcnt", int'(fcnt), 0);
`endif
        chk("cont_viol", viol, 0);

        // Reset in the middle of a line, then a clean frame.
        mode = 2'd1;
        mon_clear();
        pulse_start();
        k = 0;
        while (!(lval && x == 11'd2) && k < 50) begin step(); k++; end
        chk("mrst_at_x2", int'(x), 2);
        rst = 1'b1;
        step();
        chk("mrst_fval", int'(fval), 0);
        chk("mrst_lval", int'(lval), 0);
        chk("mrst_d", int'(d), 0);
        chk("mrst_x", int'(x), 0);
        chk("mrst_y", int'(y), 0);
        chk("mrst_done", int'(done), 0);
        chk("mrst_fcnt", int'(fcnt), 0);
        rst = 1'b0;
        step(2);
        mon_clear();
        pulse_start();
        chk("mrst_restart_fval", int'(fval), 1);
        wait_frames(1);
        check_frame("mrst_frame", vecs[1].exp_d);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
